// File: rtl/ysyx_22050039_ifb.sv
// Instruction fetch buffer: issues in-order instruction reads and
// holds up to two returned instructions for the core.
module ysyx_22050039_ifb #(
    parameter int              XLEN     = 64,
    parameter int              INST_LEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [XLEN-1:0]     mem_req_addr,
    input  logic                mem_rsp_valid,
    input  logic [INST_LEN-1:0] mem_rsp_data,
    input  logic                mem_rsp_err,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [INST_LEN-1:0] inst,
    output logic [XLEN-1:0]     inst_pc,
    output logic                inst_err
);

    typedef enum logic [1:0] {BOOT, FETCH, DRAIN, HALT} state_t;

    state_t state, state_nxt, resume;

    logic [XLEN-1:0]     fetch_pc;
    logic [1:0]          out_cnt, out_cnt_nxt;
    logic [1:0]          fifo_cnt;
    logic                fifo_rd, fifo_wr;
    logic [INST_LEN-1:0] fifo_inst [2];
    logic [XLEN-1:0]     fifo_pc [2];
    logic [1:0]          fifo_err;
    logic [XLEN-1:0]     tag_pc [2];
    logic                tag_rd, tag_wr;
    logic                req_fire, rsp_take, flush, enq, deq;
    logic [2:0]          in_flight;

    assign in_flight   = {1'b0, out_cnt} + {1'b0, fifo_cnt};
    assign req_fire    = mem_req_valid && mem_req_ready;
    assign rsp_take    = mem_rsp_valid && (out_cnt != 2'd0);
    assign deq         = inst_valid && inst_ready && !flush;
    assign out_cnt_nxt = out_cnt + {1'b0, req_fire} - {1'b0, rsp_take};
    assign resume      = (out_cnt_nxt != 2'd0) ? DRAIN : FETCH;

    assign mem_req_addr = fetch_pc;
    assign inst_valid   = (fifo_cnt != 2'd0);
    assign inst         = fifo_inst[fifo_rd];
    assign inst_pc      = fifo_pc[fifo_rd];
    assign inst_err     = fifo_err[fifo_rd];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= BOOT;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            BOOT:  state_nxt = FETCH;
            FETCH: begin
                if (flush)                    state_nxt = resume;
                else if (enq && mem_rsp_err)  state_nxt = HALT;
            end
            DRAIN: state_nxt = resume;
            HALT:  if (flush) state_nxt = resume;
        endcase
    end

    always_comb begin
        mem_req_valid = 1'b0;
        flush         = 1'b0;
        enq           = 1'b0;
        unique case (state)
            BOOT: ;
            FETCH: begin
                flush         = redirect;
                mem_req_valid = !redirect && (in_flight < 3'd2);
                enq           = rsp_take && !redirect;
            end
            DRAIN, HALT: flush = redirect;
        endcase
    end

    // Tag queue pops on every accepted response, so drained ones stay aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc  <= RESET_PC;
            out_cnt   <= 2'd0;
            tag_rd    <= 1'b0;
            tag_wr    <= 1'b0;
            tag_pc[0] <= '0;
            tag_pc[1] <= '0;
        end else begin
            out_cnt <= out_cnt_nxt;
            if (flush)
                fetch_pc <= redirect_pc & ~(XLEN'(3));
            else if (req_fire)
                fetch_pc <= fetch_pc + XLEN'(4);
            if (req_fire) begin
                tag_pc[tag_wr] <= fetch_pc;
                tag_wr         <= !tag_wr;
            end
            if (rsp_take) tag_rd <= !tag_rd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_cnt     <= 2'd0;
            fifo_rd      <= 1'b0;
            fifo_wr      <= 1'b0;
            fifo_inst[0] <= '0;
            fifo_inst[1] <= '0;
            fifo_pc[0]   <= '0;
            fifo_pc[1]   <= '0;
            fifo_err     <= 2'b00;
        end else if (flush) begin
            fifo_cnt <= 2'd0;
            fifo_rd  <= 1'b0;
            fifo_wr  <= 1'b0;
        end else begin
            if (enq) begin
                fifo_inst[fifo_wr] <= mem_rsp_data;
                fifo_pc[fifo_wr]   <= tag_pc[tag_rd];
                fifo_err[fifo_wr]  <= mem_rsp_err;
                fifo_wr            <= !fifo_wr;
            end
            if (deq) fifo_rd <= !fifo_rd;
            fifo_cnt <= fifo_cnt + {1'b0, enq} - {1'b0, deq};
        end
    end

endmodule

// File: doc/ysyx_22050039_ifb.md
YSYX_22050039_IFB -- requirements
Module: ysyx_22050039_ifb

Interface
REQ-001 SHALL have parameters: XLEN, 64, data/address width; INST_LEN, 32, instruction width; RESET_PC, 64'h8000_0000, first fetch address.
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-004 SHALL have ports: rst  in  1  asynchronous reset, active low.
REQ-005 SHALL have ports: redirect  in  1  flush and restart fetch; redirect_pc  in  XLEN  new fetch address.
REQ-006 SHALL have ports: mem_req_valid  out  1; mem_req_ready  in  1; mem_req_addr  out  XLEN  instruction-memory read request.
REQ-007 SHALL have ports: mem_rsp_valid  in  1; mem_rsp_data  in  INST_LEN; mem_rsp_err  in  1  in-order read response, no backpressure.
REQ-008 SHALL have ports: inst_valid  out  1; inst_ready  in  1; inst  out  INST_LEN; inst_pc  out  XLEN; inst_err  out  1  instruction stream to core.

Function
REQ-009 SHALL hold fetch_pc, a 2-entry FIFO of {inst, pc, err}, outstanding counter out_cnt (0..2) and FSM states BOOT, FETCH, DRAIN, HALT.
REQ-010 SHALL assert mem_req_valid only when all hold: state==FETCH, out_cnt+fifo_count<2, redirect==0; mem_req_addr SHALL equal fetch_pc.
REQ-011 SHALL, on mem_req_valid&&mem_req_ready, increment out_cnt, record the request pc in an in-order tag queue, and set fetch_pc = fetch_pc+4 (modulo 2^XLEN; wrap from all-ones-minus-3 to 0).
REQ-012 SHALL, on mem_rsp_valid in FETCH with out_cnt>0, enqueue {mem_rsp_data, tag pc, mem_rsp_err}, decrement out_cnt; inst_valid rises on the following cycle (no fall-through).
REQ-013 SHALL ignore mem_rsp_valid when out_cnt==0 (spurious response; no state change).
REQ-014 SHALL present FIFO head on inst/inst_pc/inst_err with inst_valid=1 when non-empty; dequeue on inst_valid&&inst_ready; simultaneous enqueue+dequeue keeps count.
REQ-015 SHALL hold inst/inst_pc/inst_err stable while inst_valid&&!inst_ready.
REQ-016 SHALL, on redirect (any state except BOOT), empty the FIFO, set fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}, and go to DRAIN if out_cnt (after this cycle's response) >0, else FETCH.
REQ-017 SHALL, in DRAIN, discard every response, decrement out_cnt, and go to FETCH in the cycle after out_cnt reaches 0; no requests issued.
REQ-018 SHALL, when an entry with err=1 is enqueued, go to HALT: no new requests; still-outstanding later responses are discarded; only redirect leaves HALT.
REQ-019 SHALL go BOOT -> FETCH one cycle after rst deasserts; redirect in BOOT is ignored.
REQ-020 SHALL give redirect priority over dequeue and enqueue in the same cycle (inst_valid=0 next cycle).

Reset
REQ-021 SHALL, while rst==0: state=BOOT, fetch_pc=RESET_PC, out_cnt=0, FIFO empty, mem_req_valid=0, inst_valid=0, inst=0, inst_pc=0, inst_err=0.
REQ-022 SHALL apply reset asynchronously mid-transaction; responses to pre-reset requests arriving afterwards fall under REQ-013.

Verification
REQ-023 Boot: release rst, mem_req_ready=1, 1-cycle memory returning pc-derived data -> first request 1 cycle after release at 0x80000000, then 0x80000004, 0x80000008; inst_pc matches in order.
REQ-024 Backpressure: inst_ready=0 -> at most 2 entries buffered, mem_req_valid drops once out_cnt+count==2, head stable; release inst_ready -> no loss, no duplication.
REQ-025 Redirect with 2 outstanding: redirect_pc=0x80001003 -> FIFO cleared, DRAIN discards 2 responses, next request at 0x80001000.
REQ-026 Error: response for 0x80000004 with mem_rsp_err=1 -> delivered with inst_err=1, HALT, no further requests; redirect to 0x80000100 resumes.
REQ-027 Wrap: redirect_pc=0xFFFFFFFF_FFFFFFFC -> requests at 0xFFFFFFFF_FFFFFFFC then 0x0.
REQ-028 Reset mid-operation: assert rst with 2 outstanding and full FIFO -> all outputs at REQ-021 values immediately; late responses ignored; fetch restarts at RESET_PC.
